// File: rtl/oc8051_int_ctrl_pkg.sv
// oc8051_int_ctrl_pkg: shared constants, state encoding and vector helper for the interrupt controller
package oc8051_int_ctrl_pkg;

    localparam logic [7:0] VEC_BASE = 8'h03;
    localparam logic [7:0] VEC_STEP = 8'h08;

    localparam logic [2:0] OC8051_INT_X0  = 3'd0;
    localparam logic [2:0] OC8051_INT_T0  = 3'd1;
    localparam logic [2:0] OC8051_INT_X1  = 3'd2;
    localparam logic [2:0] OC8051_INT_T1  = 3'd3;
    localparam logic [2:0] OC8051_INT_SER = 3'd4;

    typedef enum logic {
        OC8051_ICS_IDLE = 1'b0,
        OC8051_ICS_WAIT = 1'b1
    } ics_t;

    function automatic logic [7:0] int_vec(input logic [2:0] idx);
        return VEC_BASE + 8'(idx) * VEC_STEP;
    endfunction

endpackage

// File: rtl/oc8051_int_prio.sv
// oc8051_int_prio: picks the winning source from the pending set, priority levels and in-service state
module oc8051_int_prio (
    input  logic [4:0] pend,
    input  logic [4:0] ip,
    input  logic       isr_hi,
    input  logic       isr_lo,
    output logic       win_valid,
    output logic [2:0] win_idx,
    output logic       win_hi
);

    logic [4:0] hi_el;
    logic [4:0] lo_el;
    logic [4:0] sel;

    // any active service routine blocks low level; only a high one blocks high level
    assign hi_el     = isr_hi ? 5'b0 : pend & ip;
    assign lo_el     = (isr_hi | isr_lo) ? 5'b0 : pend & ~ip;
    assign win_hi    = |hi_el;
    assign sel       = win_hi ? hi_el : lo_el;
    assign win_valid = |sel;

    always_comb begin
        win_idx = 3'd0;
        for (int i = 4; i >= 0; i--)
            if (sel[i]) win_idx = 3'(i);
    end

endmodule

// File: rtl/oc8051_int_ctrl.sv
// oc8051_int_ctrl: masks, prioritises and issues 8051 interrupt requests to instruction select,
// tracking in-service levels until RETI and clearing hardware-cleared TCON flags on acknowledge
module oc8051_int_ctrl
    import oc8051_int_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ie,
    input  logic [7:0] ip,
    input  logic       it0,
    input  logic       it1,
    input  logic       ie0,
    input  logic       tf0,
    input  logic       ie1,
    input  logic       tf1,
    input  logic       ri,
    input  logic       ti,
    input  logic       reti,
    input  logic       ack,
    output logic       int_req,
    output logic [7:0] int_v,
    output logic       clr_ie0,
    output logic       clr_tf0,
    output logic       clr_ie1,
    output logic       clr_tf1,
    output logic       busy
);

    ics_t       state, state_n;
    logic [4:0] pend;
    logic       win_valid, win_hi;
    logic [2:0] win_idx;
    logic [2:0] idx_q;
    logic       hi_q;
    logic       isr_hi, isr_lo, isr_hi_n, isr_lo_n;
    logic       issue, acked;
    logic       unused_bits;

    assign unused_bits = &{ie[6:5], ip[7:5]};
    assign pend        = {ri | ti, tf1, ie1, tf0, ie0} & ie[4:0] & {5{ie[7]}};
    assign busy        = (state == OC8051_ICS_WAIT);

    oc8051_int_prio u_prio (
        .pend      (pend),
        .ip        (ip[4:0]),
        .isr_hi    (isr_hi),
        .isr_lo    (isr_lo),
        .win_valid (win_valid),
        .win_idx   (win_idx),
        .win_hi    (win_hi)
    );

    always_comb begin
        issue   = (state == OC8051_ICS_IDLE) && win_valid && !reti;
        acked   = (state == OC8051_ICS_WAIT) && ack;
        state_n = issue ? OC8051_ICS_WAIT : acked ? OC8051_ICS_IDLE : state;
        // reti clears from pre-cycle state; an ack set on the same bit overrides it
        isr_hi_n = (acked & hi_q) | (isr_hi & ~reti);
        isr_lo_n = (acked & ~hi_q) | (isr_lo & ~(reti & ~isr_hi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= OC8051_ICS_IDLE;
            int_req <= 1'b0;
            int_v   <= 8'h00;
            idx_q   <= 3'd0;
            hi_q    <= 1'b0;
            isr_hi  <= 1'b0;
            isr_lo  <= 1'b0;
            clr_ie0 <= 1'b0;
            clr_tf0 <= 1'b0;
            clr_ie1 <= 1'b0;
            clr_tf1 <= 1'b0;
        end else begin
            state   <= state_n;
            int_req <= issue;
            if (issue) begin
                int_v <= int_vec(win_idx);
                idx_q <= win_idx;
                hi_q  <= win_hi;
            end
            isr_hi  <= isr_hi_n;
            isr_lo  <= isr_lo_n;
            clr_ie0 <= acked && idx_q == OC8051_INT_X0 && it0;
            clr_tf0 <= acked && idx_q == OC8051_INT_T0;
            clr_ie1 <= acked && idx_q == OC8051_INT_X1 && it1;
            clr_tf1 <= acked && idx_q == OC8051_INT_T1;
        end
    end

endmodule

// File: tb/tb_oc8051_int_ctrl.sv
// tb_oc8051_int_ctrl: scoreboard bench; expected vectors and issue cycles are queued with the stimulus
module tb_oc8051_int_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ie = 8'h00;
    logic [7:0] ip = 8'h00;
    logic       it0 = 1'b0, it1 = 1'b0;
    logic       ie0 = 1'b0, tf0 = 1'b0, ie1 = 1'b0, tf1 = 1'b0, ri = 1'b0, ti = 1'b0;
    logic       reti = 1'b0, ack = 1'b0;
    logic       int_req, busy;
    logic [7:0] int_v;
    logic       clr_ie0, clr_tf0, clr_ie1, clr_tf1;

    typedef struct {
        int         cyc;
        logic [7:0] v;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    oc8051_int_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .ie      (ie),
        .ip      (ip),
        .it0     (it0),
        .it1     (it1),
        .ie0     (ie0),
        .tf0     (tf0),
        .ie1     (ie1),
        .tf1     (tf1),
        .ri      (ri),
        .ti      (ti),
        .reti    (reti),
        .ack     (ack),
        .int_req (int_req),
        .int_v   (int_v),
        .clr_ie0 (clr_ie0),
        .clr_tf0 (clr_tf0),
        .clr_ie1 (clr_ie1),
        .clr_tf1 (clr_tf1),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_int(input int dly, input logic [7:0] v);
        q.push_back('{cyc + dly, v});
    endtask

    task automatic chk_clr(input string tag, input logic [3:0] exp);
        chk(tag, {clr_ie0, clr_tf0, clr_ie1, clr_tf1}, exp);
    endtask

    task automatic chk_isr(input string tag, input logic hi, input logic lo);
        chk(tag, {dut.isr_hi, dut.isr_lo}, {hi, lo});
    endtask

    task automatic do_ack;
        ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    task automatic do_reti;
        reti = 1'b1;
        step(1);
        reti = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && int_req) begin
            if (q.size() == 0) begin
                chk("unexpected_int", int_v, 32'hffff_ffff);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("int_v", int_v, e.v);
                chk("int_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        step(2);
        chk("rst_int", int_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_int_v", int_v, 0);
        chk_clr("rst_clr", 4'b0000);
        chk_isr("rst_isr", 0, 0);
        rst = 1'b0;
        step(1);

        // external 0, edge mode: served at low level, flag cleared on ack
        ie = 8'h81; it0 = 1'b1; ie0 = 1'b1;
        expect_int(1, 8'h03);
        step(1);
        chk("x0_busy", busy, 1);
        step(3);
        chk("x0_hold_v", int_v, 8'h03);
        chk("x0_busy_hold", busy, 1);
        do_ack;
        ie0 = 1'b0;
        chk_clr("x0_clr", 4'b1000);
        chk_isr("x0_isr", 0, 1);
        chk("x0_busy_done", busy, 0);
        step(1);
        chk_clr("x0_clr_end", 4'b0000);
        do_reti;
        chk_isr("x0_reti", 0, 0);

        // tf1 outranks serial at the same level; serial follows after reti
        ie = 8'h9F; ip = 8'h00; tf1 = 1'b1; ri = 1'b1;
        expect_int(1, 8'h1B);
        step(2);
        do_ack;
        tf1 = 1'b0;
        chk_clr("t1_clr", 4'b0001);
        chk_isr("t1_isr", 0, 1);
        step(2);
        expect_int(2, 8'h23);
        do_reti;
        step(2);
        do_ack;
        ri = 1'b0;
        chk_clr("ser_noclr", 4'b0000);
        do_reti;
        chk_isr("ser_done", 0, 0);

        // high-priority serial preempts a low routine; low tf0 needs both retis
        tf0 = 1'b1;
        expect_int(1, 8'h0B);
        step(2);
        do_ack;
        tf0 = 1'b0;
        chk_isr("pre_lo", 0, 1);
        ip = 8'h10; ri = 1'b1;
        expect_int(1, 8'h23);
        step(2);
        do_ack;
        ri = 1'b0;
        chk_isr("pre_hi", 1, 1);
        tf0 = 1'b1;
        step(3);
        do_reti;
        chk_isr("pre_reti1", 0, 1);
        step(3);
        expect_int(2, 8'h0B);
        do_reti;
        step(2);
        do_ack;
        tf0 = 1'b0;
        chk_clr("pre_t0_clr", 4'b0100);
        do_reti;
        chk_isr("pre_done", 0, 0);

        // EA gating
        ip = 8'h00; ie = 8'h1F;
        ie0 = 1'b1; tf0 = 1'b1; ie1 = 1'b1; tf1 = 1'b1; ri = 1'b1; ti = 1'b1;
        step(3);
        chk("ea0_busy", busy, 0);
        ie = 8'h9F;
        expect_int(1, 8'h03);
        step(2);
        do_ack;
        ie0 = 1'b0; tf0 = 1'b0; ie1 = 1'b0; tf1 = 1'b0; ri = 1'b0; ti = 1'b0;
        do_reti;
        chk_isr("ea_done", 0, 0);

        // level external 1: same-cycle reti/ack keeps isr_lo, no clr_ie1
        it1 = 1'b0; ie1 = 1'b1;
        expect_int(1, 8'h13);
        step(2);
        reti = 1'b1;
        do_ack;
        reti = 1'b0;
        ie1 = 1'b0;
        chk_clr("x1_noclr", 4'b0000);
        chk_isr("same_lo", 0, 1);
        ip = 8'h08; tf1 = 1'b1;
        expect_int(1, 8'h1B);
        step(2);
        reti = 1'b1;
        do_ack;
        reti = 1'b0;
        tf1 = 1'b0;
        chk_isr("same_hi", 1, 0);
        do_reti;
        chk_isr("same_done", 0, 0);

        // reset in WAIT abandons the request; later ack ignored
        ip = 8'h00; ie0 = 1'b1;
        expect_int(1, 8'h03);
        step(2);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1; ie0 = 1'b0;
        step(1);
        rst = 1'b0;
        chk("rst2_busy", busy, 0);
        chk("rst2_int_v", int_v, 0);
        do_ack;
        chk_clr("rst2_clr", 4'b0000);
        chk_isr("rst2_isr", 0, 0);
        chk("rst2_busy_after", busy, 0);
        step(3);

        chk("sb_left", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
